serial_frame_receiver: RTL and testbench



---
 rtl/serial_frame_receiver.sv | 174 +++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//
// Deserializes 55-bit frames from the single-wire token link. A frame is one
// start bit (1), 55 data bits LSB first, an optional even-parity bit and one
// stop bit (0). The last good frame is held on RX_Data. It is flagged to the
// consumer through a ready-qualified, registered valid.
//
// Compile-time option:
//   RX_PARITY_EN  - when defined, an even-parity bit follows data bit 54. A
//                   frame is good only if the XOR of the 55 data bits and the
//                   parity bit is 0. The frame is then 58 bits instead of 57.
// -----------------------------------------------------------------------------
module serial_frame_receiver (
  input  logic        Clk_S,
  input  logic        Rst_n,
  input  logic        S_Data,
  input  logic        RX_Ready,
  output logic        RX_Data_Valid,
  output logic [54:0] RX_Data
);

  localparam int unsigned DATA_W   = 55;
  localparam logic [5:0]  LAST_BIT = 6'(DATA_W - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;
`endif

  state_t              r_state;
  state_t              w_next_state;
  logic [5:0]          r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_pending;
  logic                w_start;
  logic                w_last_bit;
  logic                w_parity_ok;
  logic                w_frame_good;

  assign w_last_bit = (r_bit_cnt == LAST_BIT);

`ifdef RX_PARITY_EN
  logic r_parity_ok;

  // Even parity: data bits and the parity bit must XOR to zero.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_parity_ok <= 1'b0;
    end else if (r_state == ST_PARITY) begin
      r_parity_ok <= ~((^r_shift) ^ S_Data);
    end
  end

  assign w_parity_ok = r_parity_ok;
`else
  assign w_parity_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the per-cycle strobes for frame start and frame accept.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    w_next_state = r_state;
    w_start      = 1'b0;
    w_frame_good = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (S_Data) begin
          w_start      = 1'b1;
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_last_bit) begin
`ifdef RX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        w_next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        // A stop bit of 0 with good parity completes a good frame. Either way
        // the receiver returns to IDLE, so a bad frame is simply dropped.
        w_frame_good = ~S_Data & w_parity_ok;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // The bit counter is cleared on start and advances once per data bit.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bit_cnt <= 6'd0;
    end else if (w_start) begin
      r_bit_cnt <= 6'd0;
    end else if (r_state == ST_DATA) begin
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end
  end

  // Capture each data bit at the index given by the counter. All 55 positions
  // are rewritten every frame, so stale bits never reach RX_Data.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    // NOTE: the shift register is still reset, so reset fully determines the
    // state and a debug view after reset shows zeros.
    if (!Rst_n) begin
      r_shift <= '0;
    end else if (r_state == ST_DATA) begin
      r_shift[r_bit_cnt] <= S_Data;
    end
  end

  // The output holding register changes only at the stop edge of a good frame.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      RX_Data <= '0;
    end else if (w_frame_good) begin
      RX_Data <= r_shift;
    end
  end

  // Pending is set by a good frame and cleared when the next start bit is taken.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pending <= 1'b0;
    end else if (w_frame_good) begin
      r_pending <= 1'b1;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end
  end

  // Valid follows pending qualified by ready, one edge late. A start bit taken
  // on the same edge suppresses valid, because that start clears pending.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      RX_Data_Valid <= 1'b0;
    end else begin
      RX_Data_Valid <= r_pending & ~w_start & RX_Ready;
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// Testbench for serial_frame_receiver.
// Frames are driven bit by bit. Expectations come from a frame-level model:
//   - the held data word;
//   - the pending flag;
//   - the valid flag, which is pending AND ready sampled at each edge.
// Build with +define+RX_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_frame_receiver;

`ifdef RX_PARITY_EN
  localparam int FRAME_LEN = 58;
`else
  localparam int FRAME_LEN = 57;
`endif

  logic        Clk_S    = 1'b0;
  logic        Rst_n    = 1'b0;
  logic        S_Data   = 1'b0;
  logic        RX_Ready = 1'b0;
  logic        RX_Data_Valid;
  logic [54:0] RX_Data;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cyc       = 0;
  int          last_stop = 0;
  int          stop_gap  = 0;
  logic [54:0] m_data    = '0;
  bit          m_pending = 1'b0;

  serial_frame_receiver dut (
    .Clk_S         (Clk_S),
    .Rst_n         (Rst_n),
    .S_Data        (S_Data),
    .RX_Ready      (RX_Ready),
    .RX_Data_Valid (RX_Data_Valid),
    .RX_Data       (RX_Data)
  );

  always #10 Clk_S = ~Clk_S;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [54:0] rand55();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[54:0];
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk_S);
    #1;
    cyc++;
  endtask

  // Idle line for n edges. At each edge valid is expected to be pending AND ready.
  task automatic idle(input int n);
    bit exp_v;
    for (int i = 0; i < n; i++) begin
      S_Data = 1'b0;
      exp_v  = m_pending & RX_Ready;
      tick();
      check("idle_valid", {63'd0, RX_Data_Valid}, {63'd0, exp_v});
      check("idle_data", {9'd0, RX_Data}, {9'd0, m_data});
    end
  endtask

  // Drive one complete frame. The frame is corrupted when bad_stop or bad_par is set.
  task automatic send_frame(input logic [54:0] d, input bit bad_stop, input bit bad_par);
    S_Data    = 1'b1;
    m_pending = 1'b0;
    tick();
    check("start_valid", {63'd0, RX_Data_Valid}, 64'd0);
    check("start_data", {9'd0, RX_Data}, {9'd0, m_data});
    for (int i = 0; i < 55; i++) begin
      S_Data = d[i];
      tick();
      check("rx_valid", {63'd0, RX_Data_Valid}, 64'd0);
      check("rx_hold", {9'd0, RX_Data}, {9'd0, m_data});
    end
`ifdef RX_PARITY_EN
    S_Data = (^d) ^ bad_par;
    tick();
    check("par_hold", {9'd0, RX_Data}, {9'd0, m_data});
`endif
    S_Data = bad_stop;
    tick();
    if (!bad_stop && !bad_par) begin
      m_data    = d;
      m_pending = 1'b1;
      stop_gap  = cyc - last_stop;
      last_stop = cyc;
    end
    check("stop_data", {9'd0, RX_Data}, {9'd0, m_data});
    check("stop_valid", {63'd0, RX_Data_Valid}, 64'd0);
    S_Data = 1'b0;
  endtask

  initial begin
    logic [54:0] pat;
    logic [54:0] d;
    bit          bad;
    pat = 55'b101101110_1110001110_101101110_1110001110_101101110_11101;

    // Reset held for 100 ns while the line toggles.
    for (int i = 0; i < 5; i++) begin
      S_Data = 1'($urandom());
      tick();
      check("rst_data", {9'd0, RX_Data}, 64'd0);
      check("rst_valid", {63'd0, RX_Data_Valid}, 64'd0);
    end
    S_Data = 1'b0;
    Rst_n  = 1'b1;
    idle(200);
    RX_Ready = 1'b1;
    idle(200);

    // Frame 3 with ready low, then ready rises.
    RX_Ready = 1'b0;
    send_frame(55'd3, 1'b0, 1'b0);
    check("f3_data", {9'd0, RX_Data}, 64'd3);
    idle(3);
    RX_Ready = 1'b1;
    idle(5);
    check("f3_valid_hi", {63'd0, RX_Data_Valid}, 64'd1);

    // Bit-exact pattern, then ready drops while the data is held.
    send_frame(pat, 1'b0, 1'b0);
    idle(3);
    RX_Ready = 1'b0;
    idle(3);
    check("pat_data", {9'd0, RX_Data}, {9'd0, pat});

    // Ready rises on the start edge: valid must stay low. Then two back-to-back frames.
    RX_Ready = 1'b1;
    send_frame(55'h1, 1'b0, 1'b0);
    check("b2b_first", {9'd0, RX_Data}, 64'h1);
    send_frame(55'h2AAAAAAAAAAAAA, 1'b0, 1'b0);
    check("b2b_gap", 64'(stop_gap), 64'(FRAME_LEN));
    idle(4);

    // Reset 600 ns into a frame, held for 200 ns.
    S_Data    = 1'b1;
    m_pending = 1'b0;
    tick();
    for (int i = 0; i < 29; i++) begin
      S_Data = 1'($urandom());
      tick();
    end
    #5;
    Rst_n = 1'b0;
    #1;
    m_data    = '0;
    m_pending = 1'b0;
    check("mid_rst_data", {9'd0, RX_Data}, 64'd0);
    check("mid_rst_valid", {63'd0, RX_Data_Valid}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      S_Data = 1'($urandom());
      tick();
      check("mid_rst_hold", {9'd0, RX_Data}, 64'd0);
    end
    S_Data = 1'b0;
    Rst_n  = 1'b1;
    d = rand55();
    send_frame(d, 1'b0, 1'b0);
    idle(3);
    check("post_rst_data", {9'd0, RX_Data}, {9'd0, d});

    // A corrupted stop bit drops the frame.
    send_frame(rand55(), 1'b1, 1'b0);
    idle(3);
    check("bad_stop_hold", {9'd0, RX_Data}, {9'd0, d});
`ifdef RX_PARITY_EN
    send_frame(rand55(), 1'b0, 1'b1);
    idle(3);
    check("bad_par_hold", {9'd0, RX_Data}, {9'd0, d});
`endif

    // Random frames with random ready, random corruption and random gaps.
    for (int n = 0; n < 25; n++) begin
      RX_Ready = 1'($urandom());
      bad      = ($urandom_range(3) == 0);
`ifdef RX_PARITY_EN
      if (bad && $urandom_range(1) == 1) send_frame(rand55(), 1'b0, 1'b1);
      else                               send_frame(rand55(), bad, 1'b0);
`else
      send_frame(rand55(), bad, 1'b0);
`endif
      idle($urandom_range(3));
      RX_Ready = 1'($urandom());
      idle($urandom_range(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
